// File: rtl/weight_tile_streamer_pkg.sv
// Shared definitions for the weight tile streamer.
//   state_t     : control FSM states (LOAD, STREAM)
//   tile_t      : one tile of elements at the default geometry (8-bit, 2x3)
//   clog2_min1  : $clog2 clamped to at least 1 bit, for pointer/counter widths
package weight_tile_streamer_pkg;

  typedef enum logic {
    LOAD   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam int unsigned WEIGHT_WIDTH_DEF = 8;
  localparam int unsigned TILE_ELEMS_DEF   = 6;

  typedef logic [WEIGHT_WIDTH_DEF-1:0] tile_t [TILE_ELEMS_DEF];

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/weight_tile_streamer_regfile.sv
// Tile storage: DEPTH entries of ELEMS elements, each WIDTH bits.
//   clk   : clock
//   clr   : synchronous clear of every entry
//   we    : write enable; waddr/wdata select and supply the entry
//   raddr : combinational read address; rdata shows that entry
module tile_register_file #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ELEMS = 6,
  parameter int unsigned DEPTH = 9,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata [ELEMS],
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata [ELEMS]
);

  logic [WIDTH-1:0] mem [DEPTH][ELEMS];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        for (int unsigned j = 0; j < ELEMS; j++) begin
          mem[i][j] <= '0;
        end
      end
    end else if (we) begin
      for (int unsigned j = 0; j < ELEMS; j++) begin
        mem[waddr][j] <= wdata[j];
      end
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < ELEMS; j++) begin
      rdata[j] = mem[raddr][j];
    end
  end

endmodule

// File: rtl/weight_tile_streamer.sv
// Captures one weight matrix as NUM_TILES tiles (grid order), then replays the
// whole tile sequence REPEAT times on a valid/ready output.
//   clk, rst        : clock, synchronous active-high reset
//   data_in*        : load-side tile and handshake (accepted only in LOAD)
//   data_out*       : emitted tile and handshake (valid only in STREAM)
//   data_out_last   : final tile of the final repetition
//   busy            : high while streaming
module weight_tile_streamer
  import weight_tile_streamer_pkg::*;
#(
  parameter int unsigned WEIGHT_WIDTH      = 8,
  parameter int unsigned W_PARALLELISM     = 2,
  parameter int unsigned W_SIZE            = 3,
  parameter int unsigned W_NUM_PARALLELISM = 3,
  parameter int unsigned IN_DEPTH          = 3,
  parameter int unsigned REPEAT            = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WEIGHT_WIDTH-1:0] data_in [W_PARALLELISM*W_SIZE],
  input  logic                    data_in_valid,
  output logic                    data_in_ready,
  output logic [WEIGHT_WIDTH-1:0] data_out [W_PARALLELISM*W_SIZE],
  output logic                    data_out_valid,
  input  logic                    data_out_ready,
  output logic                    data_out_last,
  output logic                    busy
);

  localparam int unsigned NUM_TILES = W_NUM_PARALLELISM * IN_DEPTH;
  localparam int unsigned ELEMS     = W_PARALLELISM * W_SIZE;
  localparam int unsigned PW        = clog2_min1(NUM_TILES);
  localparam int unsigned RW        = clog2_min1(REPEAT);
  localparam logic [PW-1:0] PTR_LAST = PW'(NUM_TILES - 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr, wr_ptr_d;
  logic [PW-1:0] rd_ptr, rd_ptr_d;
  logic [RW-1:0] rep_cnt, rep_cnt_d;
  logic          wr_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rep_cnt <= '0;
    end else begin
      state_q <= state_d;
      wr_ptr  <= wr_ptr_d;
      rd_ptr  <= rd_ptr_d;
      rep_cnt <= rep_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr;
    rd_ptr_d       = rd_ptr;
    rep_cnt_d      = rep_cnt;
    data_in_ready  = 1'b0;
    data_out_valid = 1'b0;
    busy           = 1'b0;
    wr_en          = 1'b0;
    case (state_q)
      LOAD: begin
        data_in_ready = 1'b1;
        if (data_in_valid) begin
          wr_en = 1'b1;
          if (wr_ptr == PTR_LAST) begin
            wr_ptr_d = '0;
            state_d  = STREAM;
          end else begin
            wr_ptr_d = wr_ptr + 1'b1;
          end
        end
      end
      STREAM: begin
        data_out_valid = 1'b1;
        busy           = 1'b1;
        if (data_out_ready) begin
          if (rd_ptr == PTR_LAST) begin
            rd_ptr_d = '0;
            if (rep_cnt == REP_LAST) begin
              rep_cnt_d = '0;
              state_d   = LOAD;
            end else begin
              rep_cnt_d = rep_cnt + 1'b1;
            end
          end else begin
            rd_ptr_d = rd_ptr + 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
    data_out_last = data_out_valid && (rd_ptr == PTR_LAST) && (rep_cnt == REP_LAST);
  end

  // Reset also clears storage, so data_out shows zeros (entry 0) after reset.
  tile_register_file #(
    .WIDTH (WEIGHT_WIDTH),
    .ELEMS (ELEMS),
    .DEPTH (NUM_TILES),
    .AW    (PW)
  ) u_regfile (
    .clk   (clk),
    .clr   (rst),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (data_out)
  );

endmodule
